// File: rtl/hd_engine_arbiter.sv
// -----------------------------------------------------------------------------
// hd_engine_arbiter
// Shares one digit-serial arithmetic engine between two requesters. A job is
// JOB_LEN digits long; the arbiter grants one requester for the whole job,
// forwards each operand digit pair to the engine, collects the result digit
// and returns it to the owner before moving on to the next digit.
//
// Ports
//   clk, asyn_reset_n        : clock, asynchronous active-low reset
//   reqN_x/y/vld, reqN_rdy   : operand digit handshake from requester N
//   reqN_p/p_vld, reqN_p_rdy : result digit handshake to requester N
//   eng_x/y_value, _vld, _rdy: operand handshakes toward the engine
//   eng_p_value, eng_out_vld/rdy : result handshake from the engine
//   eng_cnt_master           : {digit_idx, 2'b00} for the engine
//   eng_clear                : one-cycle engine clear at job start
//   grant                    : one-hot owner {req1, req0}, 00 when idle
//   busy                     : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module hd_engine_arbiter #(
    parameter int RAM_ADDR_WIDTH = 7,
    parameter int JOB_LEN        = 16
) (
    input  logic                      clk,
    input  logic                      asyn_reset_n,
    input  logic [1:0]                req0_x,
    input  logic [1:0]                req0_y,
    input  logic                      req0_vld,
    output logic                      req0_rdy,
    output logic [1:0]                req0_p,
    output logic                      req0_p_vld,
    input  logic                      req0_p_rdy,
    input  logic [1:0]                req1_x,
    input  logic [1:0]                req1_y,
    input  logic                      req1_vld,
    output logic                      req1_rdy,
    output logic [1:0]                req1_p,
    output logic                      req1_p_vld,
    input  logic                      req1_p_rdy,
    output logic [1:0]                eng_x_value,
    output logic [1:0]                eng_y_value,
    output logic                      eng_x_vld,
    output logic                      eng_y_vld,
    input  logic                      eng_x_rdy,
    input  logic                      eng_y_rdy,
    input  logic [1:0]                eng_p_value,
    input  logic                      eng_out_vld,
    output logic                      eng_out_rdy,
    output logic [RAM_ADDR_WIDTH+1:0] eng_cnt_master,
    output logic                      eng_clear,
    output logic [1:0]                grant,
    output logic                      busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ISSUE, S_SEND, S_WAIT, S_RETURN
    } state_t;

    localparam logic [RAM_ADDR_WIDTH-1:0] LAST_IDX = RAM_ADDR_WIDTH'(JOB_LEN - 1);

    state_t                    r_state, w_state_next;
    logic [1:0]                r_grant, w_grant_next;
    logic                      r_last, w_last_next;   // index of the last owner
    logic [RAM_ADDR_WIDTH-1:0] r_idx, w_idx_next;
    logic [RAM_ADDR_WIDTH+1:0] r_cnt, w_cnt_next;
    logic                      r_clear, w_clear_next;
    logic                      r_busy, w_busy_next;
    logic [1:0]                r_x, w_x_next, r_y, w_y_next;
    logic                      r_xvld, w_xvld_next, r_yvld, w_yvld_next;
    logic [1:0]                r_p0, w_p0_next, r_p1, w_p1_next;
    logic                      r_pvld0, w_pvld0_next, r_pvld1, w_pvld1_next;

    logic                      w_owner;      // 1 when req1 holds the grant
    logic                      w_own_vld;
    logic                      w_own_p_rdy;
    logic                      w_pick;       // 1 when req1 wins arbitration
    logic [RAM_ADDR_WIDTH-1:0] w_idx_inc;

    assign w_owner     = r_grant[1];
    assign w_own_vld   = w_owner ? req1_vld   : req0_vld;
    assign w_own_p_rdy = w_owner ? req1_p_rdy : req0_p_rdy;
    // On a tie the requester that was not served last wins.
    assign w_pick      = (req0_vld && req1_vld) ? ~r_last : req1_vld;
    assign w_idx_inc   = r_idx + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_clear_next = r_clear;
        w_busy_next  = r_busy;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_xvld_next  = r_xvld;
        w_yvld_next  = r_yvld;
        w_p0_next    = r_p0;
        w_p1_next    = r_p1;
        w_pvld0_next = r_pvld0;
        w_pvld1_next = r_pvld1;
        case (r_state)
            S_IDLE: begin
                if (req0_vld || req1_vld) begin
                    w_grant_next = w_pick ? 2'b10 : 2'b01;
                    w_idx_next   = '0;
                    w_cnt_next   = '0;
                    w_clear_next = 1'b1;
                    w_busy_next  = 1'b1;
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_clear_next = 1'b0;
                w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                // Owner's rdy is high in this state, so vld alone completes it.
                if (w_own_vld) begin
                    w_x_next     = w_owner ? req1_x : req0_x;
                    w_y_next     = w_owner ? req1_y : req0_y;
                    w_xvld_next  = 1'b1;
                    w_yvld_next  = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                // Each operand channel retires on its own handshake.
                if (r_xvld && eng_x_rdy) w_xvld_next = 1'b0;
                if (r_yvld && eng_y_rdy) w_yvld_next = 1'b0;
                if ((!r_xvld || eng_x_rdy) && (!r_yvld || eng_y_rdy))
                    w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (eng_out_vld) begin
                    if (w_owner) begin
                        w_p1_next    = eng_p_value;
                        w_pvld1_next = 1'b1;
                    end else begin
                        w_p0_next    = eng_p_value;
                        w_pvld0_next = 1'b1;
                    end
                    w_state_next = S_RETURN;
                end
            end
            S_RETURN: begin
                if (w_own_p_rdy) begin
                    w_pvld0_next = 1'b0;
                    w_pvld1_next = 1'b0;
                    if (r_idx == LAST_IDX) begin
                        w_grant_next = 2'b00;
                        w_last_next  = w_owner;
                        w_busy_next  = 1'b0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_idx_next   = w_idx_inc;
                        w_cnt_next   = {w_idx_inc, 2'b00};
                        w_state_next = S_ISSUE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
            r_last  <= 1'b1;     // pretend req1 was last so req0 wins first
            r_idx   <= '0;
            r_cnt   <= '0;
            r_clear <= 1'b0;
            r_busy  <= 1'b0;
            r_x     <= 2'b00;
            r_y     <= 2'b00;
            r_xvld  <= 1'b0;
            r_yvld  <= 1'b0;
            r_p0    <= 2'b00;
            r_p1    <= 2'b00;
            r_pvld0 <= 1'b0;
            r_pvld1 <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_clear <= w_clear_next;
            r_busy  <= w_busy_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_xvld  <= w_xvld_next;
            r_yvld  <= w_yvld_next;
            r_p0    <= w_p0_next;
            r_p1    <= w_p1_next;
            r_pvld0 <= w_pvld0_next;
            r_pvld1 <= w_pvld1_next;
        end
    end

    assign req0_rdy       = (r_state == S_ISSUE) && r_grant[0];
    assign req1_rdy       = (r_state == S_ISSUE) && r_grant[1];
    assign eng_out_rdy    = (r_state == S_WAIT);
    assign req0_p         = r_p0;
    assign req0_p_vld     = r_pvld0;
    assign req1_p         = r_p1;
    assign req1_p_vld     = r_pvld1;
    assign eng_x_value    = r_x;
    assign eng_y_value    = r_y;
    assign eng_x_vld      = r_xvld;
    assign eng_y_vld      = r_yvld;
    assign eng_cnt_master = r_cnt;
    assign eng_clear      = r_clear;
    assign grant          = r_grant;
    assign busy           = r_busy;

endmodule

// File: tb/tb_hd_engine_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hd_engine_arbiter
// Directed bench: a cycle table walks two back-to-back jobs (JOB_LEN=4) with an
// always-ready engine; hand sequences cover split operand handshakes, result
// stall, engine result during ISSUE and asynchronous reset mid-job. A second
// instance with JOB_LEN=1 shares the inputs to check single-digit release.
// -----------------------------------------------------------------------------
module tb_hd_engine_arbiter;

    localparam int W = 7;

    logic       clk = 1'b0;
    logic       asyn_reset_n;
    logic [1:0] req0_x, req0_y, req1_x, req1_y, eng_p_value;
    logic       req0_vld, req1_vld, req0_p_rdy, req1_p_rdy;
    logic       eng_x_rdy, eng_y_rdy, eng_out_vld;

    logic       req0_rdy, req1_rdy, req0_p_vld, req1_p_vld;
    logic [1:0] req0_p, req1_p, eng_x_value, eng_y_value, grant;
    logic       eng_x_vld, eng_y_vld, eng_out_rdy, eng_clear, busy;
    logic [W+1:0] eng_cnt_master;

    logic       d1_req0_rdy, d1_req1_rdy, d1_req0_p_vld, d1_req1_p_vld;
    logic [1:0] d1_req0_p, d1_req1_p, d1_eng_x_value, d1_eng_y_value, d1_grant;
    logic       d1_eng_x_vld, d1_eng_y_vld, d1_eng_out_rdy, d1_eng_clear, d1_busy;
    logic [W+1:0] d1_eng_cnt_master;

    always #5 clk = ~clk;

    hd_engine_arbiter #(.RAM_ADDR_WIDTH(W), .JOB_LEN(4)) u_dut (
        .clk(clk), .asyn_reset_n(asyn_reset_n),
        .req0_x(req0_x), .req0_y(req0_y), .req0_vld(req0_vld), .req0_rdy(req0_rdy),
        .req0_p(req0_p), .req0_p_vld(req0_p_vld), .req0_p_rdy(req0_p_rdy),
        .req1_x(req1_x), .req1_y(req1_y), .req1_vld(req1_vld), .req1_rdy(req1_rdy),
        .req1_p(req1_p), .req1_p_vld(req1_p_vld), .req1_p_rdy(req1_p_rdy),
        .eng_x_value(eng_x_value), .eng_y_value(eng_y_value),
        .eng_x_vld(eng_x_vld), .eng_y_vld(eng_y_vld),
        .eng_x_rdy(eng_x_rdy), .eng_y_rdy(eng_y_rdy),
        .eng_p_value(eng_p_value), .eng_out_vld(eng_out_vld), .eng_out_rdy(eng_out_rdy),
        .eng_cnt_master(eng_cnt_master), .eng_clear(eng_clear),
        .grant(grant), .busy(busy)
    );

    hd_engine_arbiter #(.RAM_ADDR_WIDTH(W), .JOB_LEN(1)) u_dut1 (
        .clk(clk), .asyn_reset_n(asyn_reset_n),
        .req0_x(req0_x), .req0_y(req0_y), .req0_vld(req0_vld), .req0_rdy(d1_req0_rdy),
        .req0_p(d1_req0_p), .req0_p_vld(d1_req0_p_vld), .req0_p_rdy(req0_p_rdy),
        .req1_x(req1_x), .req1_y(req1_y), .req1_vld(req1_vld), .req1_rdy(d1_req1_rdy),
        .req1_p(d1_req1_p), .req1_p_vld(d1_req1_p_vld), .req1_p_rdy(req1_p_rdy),
        .eng_x_value(d1_eng_x_value), .eng_y_value(d1_eng_y_value),
        .eng_x_vld(d1_eng_x_vld), .eng_y_vld(d1_eng_y_vld),
        .eng_x_rdy(eng_x_rdy), .eng_y_rdy(eng_y_rdy),
        .eng_p_value(eng_p_value), .eng_out_vld(eng_out_vld), .eng_out_rdy(d1_eng_out_rdy),
        .eng_cnt_master(d1_eng_cnt_master), .eng_clear(d1_eng_clear),
        .grant(d1_grant), .busy(d1_busy)
    );

    typedef struct {
        logic       v0, v1;
        logic [1:0] grant;
        logic       busy, clr, rdy0, rdy1, xvld, ordy, pvld0;
        logic [1:0] p0;
        logic [8:0] cnt;
    } vec_t;

    vec_t vecs[32];
    int   nv = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] g, input logic b, input logic c, input logic r0,
                       input logic r1, input logic xv, input logic orr, input logic pv,
                       input logic [1:0] p, input int cnt);
        vecs[nv].v0 = 1'b1;  vecs[nv].v1 = 1'b1;
        vecs[nv].grant = g;  vecs[nv].busy = b;  vecs[nv].clr = c;
        vecs[nv].rdy0 = r0;  vecs[nv].rdy1 = r1; vecs[nv].xvld = xv;
        vecs[nv].ordy = orr; vecs[nv].pvld0 = pv; vecs[nv].p0 = p;
        vecs[nv].cnt = 9'(cnt);
        nv++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_inputs_idle();
        req0_x = 2'b00; req0_y = 2'b00; req1_x = 2'b00; req1_y = 2'b00;
        req0_vld = 1'b0; req1_vld = 1'b0; req0_p_rdy = 1'b0; req1_p_rdy = 1'b0;
        eng_x_rdy = 1'b0; eng_y_rdy = 1'b0; eng_out_vld = 1'b0; eng_p_value = 2'b00;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, grant, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_clear"}, eng_clear, 1'b0);
        chk({tag, "_xy_value"}, {eng_x_value, eng_y_value}, 4'h0);
        chk({tag, "_eng_vld"}, {eng_x_vld, eng_y_vld}, 2'b00);
        chk({tag, "_rdys"}, {req0_rdy, req1_rdy, eng_out_rdy}, 3'b000);
        chk({tag, "_p_vld"}, {req0_p_vld, req1_p_vld}, 2'b00);
        chk({tag, "_p"}, {req0_p, req1_p}, 4'h0);
        chk({tag, "_cnt"}, eng_cnt_master, 9'd0);
    endtask

    task automatic pulse_reset();
        asyn_reset_n = 1'b0;
        all_inputs_idle();
        tick();
        tick();
        asyn_reset_n = 1'b1;
    endtask

    initial begin
        all_inputs_idle();
        asyn_reset_n = 1'b1;
        #1 asyn_reset_n = 1'b0;
        #1 chk_reset_outputs("por");
        tick();
        tick();
        asyn_reset_n = 1'b1;

        // ---------------- table: two jobs, both requesters asking ----------
        //   grant  busy clr rdy0 rdy1 xvld ordy pvld0 p0 cnt
        add(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);   // IDLE
        add(2'b01, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0);   // CLEAR
        for (int d = 0; d < 4; d++) begin
            logic [1:0] pp;
            pp = (d == 0) ? 2'b00 : 2'b10;
            add(2'b01, 1, 0, 1, 0, 0, 0, 0, pp,    4 * d);  // ISSUE
            add(2'b01, 1, 0, 0, 0, 1, 0, 0, pp,    4 * d);  // SEND
            add(2'b01, 1, 0, 0, 0, 0, 1, 0, pp,    4 * d);  // WAIT
            add(2'b01, 1, 0, 0, 0, 0, 0, 1, 2'b10, 4 * d);  // RETURN
        end
        add(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 12);  // IDLE, job done
        add(2'b10, 1, 1, 0, 0, 0, 0, 0, 2'b10, 0);   // CLEAR for req1
        add(2'b10, 1, 0, 0, 1, 0, 0, 0, 2'b10, 0);   // ISSUE for req1

        req0_x = 2'b01; req0_y = 2'b11; req1_x = 2'b10; req1_y = 2'b00;
        eng_x_rdy = 1'b1; eng_y_rdy = 1'b1; eng_out_vld = 1'b1; eng_p_value = 2'b10;
        req0_p_rdy = 1'b1; req1_p_rdy = 1'b1;
        for (int i = 0; i < nv; i++) begin
            req0_vld = vecs[i].v0;
            req1_vld = vecs[i].v1;
            $display("row %0d: grant=%b busy=%b clr=%b rdy=%b%b xvld=%b ordy=%b pvld0=%b p0=%b cnt=%0d",
                     i, grant, busy, eng_clear, req1_rdy, req0_rdy, eng_x_vld, eng_out_rdy,
                     req0_p_vld, req0_p, eng_cnt_master);
            chk($sformatf("row%0d_grant", i), grant, vecs[i].grant);
            chk($sformatf("row%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("row%0d_clear", i), eng_clear, vecs[i].clr);
            chk($sformatf("row%0d_rdy0", i), req0_rdy, vecs[i].rdy0);
            chk($sformatf("row%0d_rdy1", i), req1_rdy, vecs[i].rdy1);
            chk($sformatf("row%0d_xyvld", i), {eng_x_vld, eng_y_vld}, {2{vecs[i].xvld}});
            chk($sformatf("row%0d_out_rdy", i), eng_out_rdy, vecs[i].ordy);
            chk($sformatf("row%0d_pvld0", i), req0_p_vld, vecs[i].pvld0);
            chk($sformatf("row%0d_pvld1", i), req1_p_vld, 1'b0);
            if (vecs[i].pvld0) chk($sformatf("row%0d_p0", i), req0_p, vecs[i].p0);
            chk($sformatf("row%0d_cnt", i), eng_cnt_master, vecs[i].cnt);
            if (i == 3) chk("row3_xy_value", {eng_x_value, eng_y_value}, 4'b0111);
            if (i == 5) chk("len1_pvld0", d1_req0_p_vld, 1'b1);
            if (i == 6) chk("len1_release", {d1_grant, d1_busy}, 3'b000);
            if (i == 7) chk("len1_next_grant", d1_grant, 2'b10);
            tick();
        end

        // ---------------- split operand handshakes, ISSUE ignores result ----
        pulse_reset();
        req0_x = 2'b10; req0_y = 2'b01; req0_vld = 1'b1; req0_p_rdy = 1'b1;
        tick();                                   // -> CLEAR
        tick();                                   // -> ISSUE
        req0_vld = 1'b0; eng_out_vld = 1'b1;
        chk("issue_out_rdy", eng_out_rdy, 1'b0);
        chk("issue_rdy0", req0_rdy, 1'b1);
        tick();
        $display("issue stall: rdy0=%b xvld=%b ordy=%b", req0_rdy, eng_x_vld, eng_out_rdy);
        chk("issue_stall_rdy0", req0_rdy, 1'b1);
        chk("issue_stall_xvld", eng_x_vld, 1'b0);
        req0_vld = 1'b1; eng_out_vld = 1'b0;
        tick();                                   // -> SEND
        chk("send_vld", {eng_x_vld, eng_y_vld}, 2'b11);
        chk("send_value", {eng_x_value, eng_y_value}, 4'b1001);
        req0_vld = 1'b0; req0_x = 2'b00; req0_y = 2'b00; eng_x_rdy = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) eng_x_rdy = 1'b0;
            if (k == 3) eng_y_rdy = 1'b1;
            $display("split t+%0d: xvld=%b yvld=%b ordy=%b", k, eng_x_vld, eng_y_vld, eng_out_rdy);
            chk($sformatf("split%0d_vld", k), {eng_x_vld, eng_y_vld}, 2'b01);
            chk($sformatf("split%0d_out_rdy", k), eng_out_rdy, 1'b0);
        end
        tick();                                   // -> WAIT
        eng_y_rdy = 1'b0;
        chk("split_wait_vld", {eng_x_vld, eng_y_vld}, 2'b00);
        chk("split_wait_out_rdy", eng_out_rdy, 1'b1);

        // ---------------- result stall in RETURN ----------------------------
        eng_p_value = 2'b01; eng_out_vld = 1'b1; req0_p_rdy = 1'b0; req1_vld = 1'b1;
        tick();                                   // -> RETURN
        eng_out_vld = 1'b0; eng_p_value = 2'b11;
        for (int k = 0; k < 5; k++) begin
            $display("stall %0d: pvld0=%b p0=%b grant=%b", k, req0_p_vld, req0_p, grant);
            chk($sformatf("stall%0d_p0", k), {req0_p_vld, req0_p}, 3'b101);
            chk($sformatf("stall%0d_xy", k), {eng_x_value, eng_y_value}, 4'b1001);
            chk($sformatf("stall%0d_req1", k), {grant, req1_rdy, req1_p_vld}, 4'b0100);
            tick();
        end
        req0_p_rdy = 1'b1; req0_vld = 1'b1; eng_x_rdy = 1'b1; eng_y_rdy = 1'b1;
        tick();                                   // -> ISSUE, digit 1
        chk("digit1_issue", {req0_rdy, req0_p_vld}, 2'b10);
        chk("digit1_cnt", eng_cnt_master, 9'd4);

        // ---------------- asynchronous reset during WAIT of digit 2 --------
        tick();                                   // SEND
        tick();                                   // WAIT
        eng_out_vld = 1'b1;
        tick();                                   // RETURN
        eng_out_vld = 1'b0;
        tick();                                   // ISSUE, digit 2
        tick();                                   // SEND
        tick();                                   // WAIT
        chk("d2_wait", {eng_out_rdy, eng_cnt_master}, {1'b1, 9'd8});
        asyn_reset_n = 1'b0; eng_out_vld = 1'b1;
        #1 chk_reset_outputs("midjob");
        @(negedge clk);
        asyn_reset_n = 1'b1; eng_out_vld = 1'b0;
        req0_vld = 1'b1; req1_vld = 1'b1;
        tick();                                   // -> CLEAR
        $display("after reset: grant=%b clr=%b cnt=%0d", grant, eng_clear, eng_cnt_master);
        chk("post_rst_clear", {eng_clear, grant, eng_cnt_master}, {1'b1, 2'b01, 9'd0});
        chk("post_rst_pvld", req0_p_vld, 1'b0);
        tick();                                   // -> ISSUE
        chk("post_rst_issue", {eng_clear, req0_rdy, req0_p_vld}, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
